// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the rv32i pipeline stall/flush sequencer: FSM state,
// the bundled stage-load control word and the canned control patterns.
package pipeline_ctrl_pkg;

  localparam int REG_W_DEF = 5;
  localparam int CNT_W_DEF = 32;

  typedef enum logic {
    RUN  = 1'b0,
    DROP = 1'b1
  } pipe_ctrl_state_t;

  typedef struct packed {
    logic load_pc;
    logic pc_sel;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic flush_if_id;
    logic bubble_id_ex;
  } pipe_loads_t;

  localparam pipe_loads_t LOADS_RESET = '{
    load_pc:      1'b0,
    pc_sel:       1'b0,
    load_if_id:   1'b0,
    load_id_ex:   1'b0,
    load_ex_mem:  1'b0,
    load_mem_wb:  1'b0,
    flush_if_id:  1'b1,
    bubble_id_ex: 1'b1
  };

  localparam pipe_loads_t LOADS_FLOW = '{
    load_pc:      1'b1,
    pc_sel:       1'b0,
    load_if_id:   1'b1,
    load_id_ex:   1'b1,
    load_ex_mem:  1'b1,
    load_mem_wb:  1'b1,
    flush_if_id:  1'b0,
    bubble_id_ex: 1'b0
  };

  localparam pipe_loads_t LOADS_FROZEN = '{
    load_pc:      1'b0,
    pc_sel:       1'b0,
    load_if_id:   1'b0,
    load_id_ex:   1'b0,
    load_ex_mem:  1'b0,
    load_mem_wb:  1'b0,
    flush_if_id:  1'b0,
    bubble_id_ex: 1'b0
  };

  localparam pipe_loads_t LOADS_REDIRECT = '{
    load_pc:      1'b1,
    pc_sel:       1'b1,
    load_if_id:   1'b1,
    load_id_ex:   1'b1,
    load_ex_mem:  1'b1,
    load_mem_wb:  1'b1,
    flush_if_id:  1'b1,
    bubble_id_ex: 1'b1
  };

  // Front end (PC, IF/ID) held, a bubble injected into ID/EX; the back end
  // advances only when told to.
  function automatic pipe_loads_t front_hold(input logic down_en, input logic flush);
    pipe_loads_t l;
    l.load_pc      = 1'b0;
    l.pc_sel       = 1'b0;
    l.load_if_id   = 1'b0;
    l.load_id_ex   = down_en;
    l.load_ex_mem  = down_en;
    l.load_mem_wb  = down_en;
    l.flush_if_id  = flush;
    l.bubble_id_ex = 1'b1;
    return l;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones.
// One cycle from inc to updated count; cleared asynchronously by rst.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage rv32i pipeline; control outputs are
// combinational from state and hazards, counters and DROP state are registered.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_req,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_br_en,
  input  logic             ex_is_jump,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  output logic             load_pc,
  output logic             pc_sel,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             bubble_id_ex,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  pipe_ctrl_state_t state_q;
  pipe_ctrl_state_t state_d;
  pipe_loads_t      loads;

  logic dstall;
  logic istall;
  logic redirect;
  logic load_use;
  logic rs1_hit;
  logic rs2_hit;
  logic stall_inc;
  logic flush_inc;

  assign dstall   = dmem_req & ~dmem_resp;
  assign istall   = imem_req & ~imem_resp;
  assign redirect = ex_valid & ((ex_is_branch & ex_br_en) | ex_is_jump);
  assign rs1_hit  = id_rs1_used & (id_rs1 == ex_rd);
  assign rs2_hit  = id_rs2_used & (id_rs2 == ex_rd);
  assign load_use = ex_valid & ex_is_load & (ex_rd != '0) & (rs1_hit | rs2_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // A redirect that leaves a fetch in flight must swallow that fetch's response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (!dstall && redirect && istall) state_d = DROP;
      DROP:    if (imem_resp) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    loads     = LOADS_FLOW;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (rst) begin
      loads = LOADS_RESET;
    end else begin
      case (state_q)
        RUN: begin
          // A redirect under dstall stays in EX and fires once memory completes.
          if (dstall) begin
            loads     = LOADS_FROZEN;
            stall_inc = 1'b1;
          end else if (redirect) begin
            loads     = LOADS_REDIRECT;
            flush_inc = 1'b1;
            stall_inc = istall;
          end else if (load_use || istall) begin
            loads     = front_hold(1'b1, 1'b0);
            stall_inc = 1'b1;
          end
        end
        DROP: begin
          loads     = front_hold(~dstall, imem_resp);
          stall_inc = 1'b1;
        end
        default: loads = LOADS_RESET;
      endcase
    end
  end

  assign load_pc      = loads.load_pc;
  assign pc_sel       = loads.pc_sel;
  assign load_if_id   = loads.load_if_id;
  assign load_id_ex   = loads.load_id_ex;
  assign load_ex_mem  = loads.load_ex_mem;
  assign load_mem_wb  = loads.load_mem_wb;
  assign flush_if_id  = loads.flush_if_id;
  assign bubble_id_ex = loads.bubble_id_ex;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage rv32i pipeline.
- Drives the load enables of the PC and the four stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB); these are the ports that are currently tied to 1'b1.
- Resolves three hazard sources per cycle: memory wait (I and D), load-use, and EX-stage redirect (taken branch/jump).
- Handles a redirect that lands while an instruction fetch is outstanding: the wrong-path response is discarded.
- Exposes saturating stall and flush performance counters.

Parameters:
REG_W, 5, register-index width
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
imem_req  in  1  fetch request outstanding this cycle
imem_resp  in  1  fetch data valid this cycle
dmem_req  in  1  MEM-stage access outstanding this cycle
dmem_resp  in  1  data access completes this cycle
ex_valid  in  1  EX stage holds a real instruction
ex_is_branch  in  1  EX instruction is a conditional branch
ex_br_en  in  1  comparator result from EX
ex_is_jump  in  1  EX instruction is jal/jalr
ex_is_load  in  1  EX instruction is a load
ex_rd  in  REG_W  EX destination register
id_rs1, id_rs2  in  REG_W  ID source registers
id_rs1_used, id_rs2_used  in  1  ID instruction reads rs1/rs2
load_pc  out  1  PC register load
pc_sel  out  1  1 = PC takes EX ALU target, 0 = pc+4
load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1  stage register loads
flush_if_id  out  1  IF/ID captures valid=0
bubble_id_ex  out  1  ID/EX captures valid=0
stall_count  out  CNT_W  cycles with any stall
flush_count  out  CNT_W  redirects taken

Behaviour:
- Derived signals:
  - dstall = dmem_req & ~dmem_resp
  - istall = imem_req & ~imem_resp
  - redirect = ex_valid & ((ex_is_branch & ex_br_en) | ex_is_jump)
  - load_use = ex_valid & ex_is_load & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd))
- Outputs are combinational from state and inputs. Counters and state are registered.
- While rst=1:
  - all loads=0, pc_sel=0, flush_if_id=1, bubble_id_ex=1
  - counters=0, state=RUN
- States: RUN, DROP.
- RUN, strict priority, first match wins:
  1. dstall: all loads=0 (whole pipe frozen). The redirect is ignored because it persists in EX. stall_count++.
  2. redirect: pc_sel=1, load_pc=1, flush_if_id=1, bubble_id_ex=1, all stage loads=1. flush_count++.
     - If istall is also set: next=DROP and stall_count++.
  3. load_use: load_pc=0, load_if_id=0, bubble_id_ex=1, load_id_ex/ex_mem/mem_wb=1. stall_count++.
  4. istall: same outputs as load_use. stall_count++.
  5. Otherwise all loads=1, no flush/bubble.
- DROP (wrong-path fetch still in flight):
  - load_pc=0, load_if_id=0, bubble_id_ex=1, pc_sel=0.
  - Downstream loads = ~dstall.
  - stall_count++ every cycle.
  - On imem_resp=1: flush_if_id=1, next=RUN. The returned instruction is never used.
  - A redirect cannot occur in DROP because EX sees only bubbles; if it is asserted anyway, it is ignored.
- Counters saturate at all-ones and never wrap. A cycle counts once even if several stall causes coincide.
- Asserting rst mid-DROP returns to RUN immediately. Any pending wrong-path response after reset is the memory's responsibility.
- ex_rd==0 never creates a load-use stall.

Decomposition:
- Add to rv32i_types:
  - enum pipe_ctrl_state_t {RUN, DROP}
  - a struct pipe_loads_t bundling the five load enables plus pc_sel, flush and bubble, so stages take a single port
- Sub-module sat_counter #(CNT_W): clk, rst, inc, count. Instantiated twice.

Test Plan:
1. No hazards, imem_resp=dmem_resp=1 for 10 cycles -> all loads=1, flush/bubble=0, both counters stay 0.
2. EX load with ex_rd=5, ID rs2=5 and rs2_used -> one cycle with load_pc=load_if_id=0 and bubble_id_ex=1; stall_count=1. Repeat with ex_rd=0 -> no stall.
3. Taken branch (ex_is_branch=1, ex_br_en=1) with fetch ready -> pc_sel=1, load_pc=1, flush_if_id=bubble_id_ex=1 for one cycle; flush_count=1; state stays RUN.
4. Taken branch while imem_req=1, imem_resp=0, with resp arriving 3 cycles later -> redirect cycle, then DROP for 3 cycles with load_if_id=0; on the resp cycle flush_if_id=1 and return to RUN; stall_count=4, flush_count=1.
5. dmem_req=1 with dmem_resp low for 4 cycles while a taken branch sits in EX -> all loads=0 for 4 cycles; the redirect fires on the cycle dmem_resp=1; stall_count=4.
6. Preload stall_count to all-ones by forcing, then stall -> value holds. Pulse rst during DROP -> state=RUN and counters=0 asynchronously, before the next clock edge.
